fetch_decode_unit: RTL and testbench

- Instruction-fetch and decode front end for the single-instruction (ADDI-immediate) datapath.
- Contains a free-running byte-address program counter and a word-addressed instruction memory with a synchronous write port and combinational read.
- Also contains a combinational decoder that extracts the destination register id and the sign-extended I-type immediate.
- Outputs drive the register-file write port (destination id, write data, write enable).

---
 rtl/fetch_decode_unit_if.sv | 39 +++
 rtl/fetch_decode_unit.sv | 72 +++++++
 tb/tb_fetch_decode_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_unit_if.sv
// Bus bundle for the fetch/decode front end: the instruction-memory
// write port going in, and the fetch/decode results going out.
interface fetch_decode_unit_if #(
  parameter int size = 7
);
  logic               mem_write_enable;
  logic [size-1:0]    mem_write_addr;
  logic [31:0]        mem_write_data;

  logic [31:0]        pc_value;
  logic [31:0]        instr;
  logic [4:0]         reg_id_d;
  logic signed [31:0] imm_value;
  logic               reg_write_enable;

  // Driver side: loads the instruction memory, observes decode results.
  modport master (
    output mem_write_enable,
    output mem_write_addr,
    output mem_write_data,
    input  pc_value,
    input  instr,
    input  reg_id_d,
    input  imm_value,
    input  reg_write_enable
  );

  // Front-end side.
  modport slave (
    input  mem_write_enable,
    input  mem_write_addr,
    input  mem_write_data,
    output pc_value,
    output instr,
    output reg_id_d,
    output imm_value,
    output reg_write_enable
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// Instruction fetch and decode front end for the ADDI-only datapath.
// A free-running byte PC indexes a word-addressed instruction memory
// (synchronous write, combinational read); the fetched word is decoded
// into destination id, sign-extended I-immediate and a write enable.
module fetch_decode_unit #(
  parameter int size = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fetch_decode_unit_if.slave    bus
);

  localparam int DEPTH = 1 << size;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [2:0] FUNCT3_ADDI   = 3'b000;

  // Sign-extend a 12-bit I-type immediate field to 32 bits.
  function automatic logic signed [31:0] sext_imm12(input logic [11:0] field);
    sext_imm12 = signed'({{20{field[11]}}, field});
  endfunction

  // ADDI is OP-IMM with funct3 zero; rs1 is never examined.
  function automatic logic is_addi(input logic [31:0] word);
    is_addi = (word[6:0] == OPCODE_OP_IMM) && (word[14:12] == FUNCT3_ADDI);
  endfunction

  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     pc_q;
  logic [31:0]     pc_d;
  logic [size-1:0] rd_idx;
  logic [31:0]     instr_w;

  // Next PC: always advance one word, wrapping naturally at 2^32.
  always_comb begin
    pc_d = pc_q + 32'd4;
  end

  // PC register; only the PC is reset, memory contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Instruction memory write port, active regardless of reset.
  always_ff @(posedge clk) begin
    if (bus.mem_write_enable) begin
      mem_q[bus.mem_write_addr] <= bus.mem_write_data;
    end
  end

  // Combinational fetch: low two PC bits and bits above the array are
  // dropped, so the PC aliases every DEPTH words.
  always_comb begin
    rd_idx  = pc_q[size+1:2];
    instr_w = mem_q[rd_idx];
  end

  // Decode straight from the fetched word; fields are driven even when
  // the instruction is not an ADDI.
  always_comb begin
    bus.pc_value         = pc_q;
    bus.instr            = instr_w;
    bus.reg_id_d         = instr_w[11:7];
    bus.imm_value        = sext_imm12(instr_w[31:20]);
    bus.reg_write_enable = is_addi(instr_w);
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: expected fetch/decode results are
// queued as each cycle is driven and compared once the DUT presents them.
module tb_fetch_decode_unit;

  localparam int SZ = 7;

  localparam logic [31:0] W0  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] W1  = 32'hFFF00113; // addi x2,x0,-1
  localparam logic [31:0] W2  = 32'h00000033; // add x0,x0,x0
  localparam logic [31:0] W3  = 32'h7FF00193; // addi x3,x0,2047
  localparam logic [31:0] W0N = 32'h00A00213; // addi x4,x0,10
  localparam logic [31:0] W2N = 32'h80002293; // slti x5,x0,-2048

  typedef struct {
    string       tag;
    logic [31:0] pc;
    bit          ci;
    logic [31:0] instr;
    bit          cd;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        we;
  } exp_t;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  fetch_decode_unit_if #(.size(SZ)) bus ();

  fetch_decode_unit #(.size(SZ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [31:0] pc,
                      input bit ci, input logic [31:0] instr,
                      input bit cd, input logic [4:0] rd,
                      input logic [31:0] imm, input logic we);
    exp_t e;
    e.tag = tag; e.pc = pc; e.ci = ci; e.instr = instr;
    e.cd = cd; e.rd = rd; e.imm = imm; e.we = we;
    sb.push_back(e);
  endtask

  task automatic wr(input logic en, input logic [SZ-1:0] addr, input logic [31:0] data);
    bus.mem_write_enable = en;
    bus.mem_write_addr   = addr;
    bus.mem_write_data   = data;
  endtask

  task automatic check_now();
    exp_t e;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL scoreboard_empty: got 0 entries want >=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      vectors++;
      assert (bus.pc_value === e.pc) else begin
        miscompares++;
        $error("FAIL %s pc_value: got %h want %h", e.tag, bus.pc_value, e.pc);
      end
      if (e.ci) begin
        vectors++;
        assert (bus.instr === e.instr) else begin
          miscompares++;
          $error("FAIL %s instr: got %h want %h", e.tag, bus.instr, e.instr);
        end
      end
      if (e.cd) begin
        vectors++;
        assert (bus.reg_id_d === e.rd) else begin
          miscompares++;
          $error("FAIL %s reg_id_d: got %0d want %0d", e.tag, bus.reg_id_d, e.rd);
        end
        vectors++;
        assert (bus.imm_value === e.imm) else begin
          miscompares++;
          $error("FAIL %s imm_value: got %h want %h", e.tag, bus.imm_value, e.imm);
        end
        vectors++;
        assert (bus.reg_write_enable === e.we) else begin
          miscompares++;
          $error("FAIL %s reg_write_enable: got %b want %b", e.tag, bus.reg_write_enable, e.we);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  initial begin
    clk = 1'b0;
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    wr(1'b0, '0, '0);
    #2;

    // Reset held for three edges while the first words are loaded.
    wr(1'b1, 7'd0, W0);
    push("rst0_w0", 32'h0, 1, W0, 1, 5'd1, 32'h00000005, 1'b1);
    tick();
    wr(1'b1, 7'd1, W1);
    push("rst1", 32'h0, 1, W0, 0, '0, '0, 1'b0);
    tick();
    wr(1'b1, 7'd2, W2);
    push("rst2", 32'h0, 1, W0, 0, '0, '0, 1'b0);
    tick();

    // Release: PC walks 4, 8.
    reset_n = 1'b1;
    wr(1'b0, '0, '0);
    push("pc4_addi_neg", 32'h4, 1, W1, 1, 5'd2, 32'hFFFFFFFF, 1'b1);
    tick();
    push("pc8_add", 32'h8, 1, W2, 1, 5'd0, 32'h00000000, 1'b0);
    tick();

    // Load word 3 while PC sits at 8; visible when PC reaches 0xC.
    wr(1'b1, 7'd3, W3);
    push("pcC_addi_max", 32'hC, 1, W3, 1, 5'd3, 32'h000007FF, 1'b1);
    tick();
    wr(1'b0, '0, '0);
    push("pc10", 32'h10, 0, '0, 0, '0, '0, 1'b0);
    tick();

    // One-edge reset pulse mid-run.
    reset_n = 1'b0;
    push("midrst", 32'h0, 1, W0, 1, 5'd1, 32'h00000005, 1'b1);
    tick();
    reset_n = 1'b1;

    // 128 cycles past reset: PC reaches 0x200, aliasing word 0.
    for (int k = 1; k <= 128; k++) begin
      case (k)
        1:       push("run_w1", 32'(4 * k), 1, W1, 0, '0, '0, 1'b0);
        2:       push("run_w2", 32'(4 * k), 1, W2, 0, '0, '0, 1'b0);
        3:       push("run_w3", 32'(4 * k), 1, W3, 0, '0, '0, 1'b0);
        128:     push("alias200", 32'h200, 1, W0, 1, 5'd1, 32'h00000005, 1'b1);
        default: push("run", 32'(4 * k), 0, '0, 0, '0, '0, 1'b0);
      endcase
      tick();
    end

    // Write the word currently being read: old word until the edge.
    wr(1'b1, 7'd0, W0N);
    #1;
    push("same_word_before", 32'h200, 1, W0, 1, 5'd1, 32'h00000005, 1'b1);
    check_now();
    push("pc204", 32'h204, 1, W1, 0, '0, '0, 1'b0);
    tick();

    // Replace word 2 with an OP-IMM non-ADDI; seen as PC lands on 0x208.
    wr(1'b1, 7'd2, W2N);
    push("slti_no_we", 32'h208, 1, W2N, 1, 5'd5, 32'hFFFFF800, 1'b0);
    tick();

    // Reset does not clear memory: word 0 now holds the rewritten value.
    wr(1'b0, '0, '0);
    reset_n = 1'b0;
    push("rst_new_w0", 32'h0, 1, W0N, 1, 5'd4, 32'h0000000A, 1'b1);
    tick();
    reset_n = 1'b1;
    push("post_w1", 32'h4, 1, W1, 1, 5'd2, 32'hFFFFFFFF, 1'b1);
    tick();
    push("post_w2n", 32'h8, 1, W2N, 1, 5'd5, 32'hFFFFF800, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
